// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: registered one-hot grant held under valid/ready backpressure.
// An owner keeps the grant for up to w_eff consecutive accepted transfers while it requests.
module arbiter_wrr #(
    parameter int unsigned  N  = 4,
    parameter int unsigned  WW = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req,
    input  logic [N*WW-1:0] i_weight,
    input  logic            i_gnt_rdy,
    output logic            o_req,
    output logic [N-1:0]    o_gnt,
    output logic [IW-1:0]   o_gnt_id,
    output logic            o_gnt_vld
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       gnt_id_q, gnt_id_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [WW-1:0]       credit_q, credit_d;

    logic [N-1:0][WW-1:0] weight_arr;
    logic [IW-1:0]        sel_ptr;
    logic [IW-1:0]        win_id;
    logic [IW-1:0]        cand;
    logic                 found;
    logic [WW-1:0]        win_weight;
    logic [WW-1:0]        reload;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Modulo-N add that stays correct when N is not a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) sum -= N;
        return IW'(sum);
    endfunction

    assign o_req      = |i_req;
    assign weight_arr = i_weight;

    // On a quota end the search already starts just past the retiring owner.
    assign sel_ptr = (state_q == StGrant) ? next_idx(gnt_id_q) : ptr_q;

    always_comb begin
        win_id = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = wrap_add(sel_ptr, i);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign win_weight = weight_arr[win_id];
    assign reload     = (win_weight == '0) ? '0 : win_weight - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            StIdle: begin
                if (o_req) begin
                    state_d  = StGrant;
                    gnt_id_d = win_id;
                    credit_d = reload;
                end
            end
            StGrant: begin
                if (i_gnt_rdy) begin
                    if (credit_q != '0 && i_req[gnt_id_q]) begin
                        credit_d = credit_q - 1'b1;
                    end else begin
                        ptr_d = next_idx(gnt_id_q);
                        if (o_req) begin
                            gnt_id_d = win_id;
                            credit_d = reload;
                        end else begin
                            state_d  = StIdle;
                            gnt_id_d = '0;
                            credit_d = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_gnt_vld = (state_q == StGrant);
        o_gnt_id  = gnt_id_q;
        o_gnt     = '0;
        if (state_q == StGrant) o_gnt[gnt_id_q] = 1'b1;
    end

    gnt_onehot_a: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));

    gnt_hold_a: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_gnt_vld && !i_gnt_rdy) |=> ($stable(o_gnt) && $stable(o_gnt_id) && $stable(credit_q)));

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: a 4-requester instance and a 3-requester instance.
module tb_arbiter_wrr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        rdy;
    logic        o_req;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_vld;

    logic        rst3;
    logic [2:0]  req3;
    logic [11:0] weight3;
    logic        rdy3;
    logic        o_req3;
    logic [2:0]  gnt3;
    logic [1:0]  gnt_id3;
    logic        gnt_vld3;

    int n_checks = 0;
    int n_errors = 0;

    arbiter_wrr #(.N(4), .WW(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_weight  (weight),
        .i_gnt_rdy (rdy),
        .o_req     (o_req),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_gnt_vld (gnt_vld)
    );

    arbiter_wrr #(.N(3), .WW(4)) dut3 (
        .i_clk     (clk),
        .i_rst     (rst3),
        .i_req     (req3),
        .i_weight  (weight3),
        .i_gnt_rdy (rdy3),
        .o_req     (o_req3),
        .o_gnt     (gnt3),
        .o_gnt_id  (gnt_id3),
        .o_gnt_vld (gnt_vld3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic vld, input logic [1:0] id,
                                input logic [3:0] g, input logic exp_vld, input int exp_id);
        logic [3:0] exp_g;
        exp_g = exp_vld ? 4'(1 << exp_id) : 4'b0000;
        check({tag, ".vld"}, 32'(vld), 32'(exp_vld));
        check({tag, ".id"}, 32'(id), exp_vld ? 32'(exp_id) : 32'd0);
        check({tag, ".gnt"}, 32'(g), 32'(exp_g));
    endtask

    int seq_rr[6]   = '{0, 1, 2, 3, 0, 1};
    int seq_w[10]   = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    int seq_n3a[5]  = '{0, 1, 2, 0, 1};
    int seq_n3b[4]  = '{0, 1, 2, 0};
    logic [3:0] bp_req[5] = '{4'b1101, 4'b0000, 4'b1111, 4'b0100, 4'b1011};

    initial begin
        rst = 1'b1; req = 4'b1111; weight = 16'h1111; rdy = 1'b1;
        rst3 = 1'b1; req3 = 3'b000; weight3 = 12'h111; rdy3 = 1'b0;
        tick();
        tick();
        // Reset overrides a live request.
        expect_grant("reset", gnt_vld, gnt_id, gnt, 1'b0, 0);
        check("o_req_or", 32'(o_req), 32'd1);

        // Plain round robin, weights 1.
        rst = 1'b0; req = 4'b0000;
        tick();
        expect_grant("idle", gnt_vld, gnt_id, gnt, 1'b0, 0);
        check("o_req_none", 32'(o_req), 32'd0);
        req = 4'b1111;
        #1;
        expect_grant("no_comb_gnt", gnt_vld, gnt_id, gnt, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_grant($sformatf("rr[%0d]", i), gnt_vld, gnt_id, gnt, 1'b1, seq_rr[i]);
        end

        // Weights w0=3 w1=1 w2=2 w3=1.
        rst = 1'b1; weight = 16'h1213;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_grant($sformatf("wrr[%0d]", i), gnt_vld, gnt_id, gnt, 1'b1, seq_w[i]);
        end

        // Backpressure on owner 1 with w1=2.
        rst = 1'b1; req = 4'b0000; weight = 16'h1121; rdy = 1'b0;
        tick();
        rst = 1'b0; req = 4'b0010;
        tick();
        expect_grant("bp_first", gnt_vld, gnt_id, gnt, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            req = bp_req[i];
            tick();
            expect_grant($sformatf("bp_hold[%0d]", i), gnt_vld, gnt_id, gnt, 1'b1, 1);
        end
        req = 4'b0110; rdy = 1'b1;
        tick();
        expect_grant("bp_extra", gnt_vld, gnt_id, gnt, 1'b1, 1);
        tick();
        expect_grant("bp_next", gnt_vld, gnt_id, gnt, 1'b1, 2);

        // Owner 0 (w0=4) drops its request mid-quota.
        rst = 1'b1; req = 4'b0011; weight = 16'h1114;
        tick();
        rst = 1'b0;
        tick();
        expect_grant("drop_g0", gnt_vld, gnt_id, gnt, 1'b1, 0);
        tick();
        expect_grant("drop_g1", gnt_vld, gnt_id, gnt, 1'b1, 0);
        tick();
        expect_grant("drop_g2", gnt_vld, gnt_id, gnt, 1'b1, 0);
        req = 4'b0010;
        tick();
        expect_grant("drop_to1", gnt_vld, gnt_id, gnt, 1'b1, 1);
        req = 4'b0011;
        tick();
        expect_grant("drop_back0", gnt_vld, gnt_id, gnt, 1'b1, 0);

        // Weight 0 acts as 1; a lone requester is granted every cycle.
        rst = 1'b1; req = 4'b0100; weight = 16'h0000;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_grant($sformatf("solo[%0d]", i), gnt_vld, gnt_id, gnt, 1'b1, 2);
        end
        req = 4'b0000;
        tick();
        expect_grant("solo_idle", gnt_vld, gnt_id, gnt, 1'b0, 0);
        tick();
        expect_grant("solo_stay", gnt_vld, gnt_id, gnt, 1'b0, 0);
        rst = 1'b1;

        // N=3: wrap 2->0, then reset during a held grant.
        req3 = 3'b111; rdy3 = 1'b1;
        tick();
        rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_grant($sformatf("n3a[%0d]", i), gnt_vld3, gnt_id3, {1'b0, gnt3}, 1'b1,
                         seq_n3a[i]);
        end
        rdy3 = 1'b0;
        tick();
        expect_grant("n3_hold", gnt_vld3, gnt_id3, {1'b0, gnt3}, 1'b1, 1);
        rst3 = 1'b1;
        tick();
        expect_grant("n3_reset", gnt_vld3, gnt_id3, {1'b0, gnt3}, 1'b0, 0);
        rst3 = 1'b0; rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_grant($sformatf("n3b[%0d]", i), gnt_vld3, gnt_id3, {1'b0, gnt3}, 1'b1,
                         seq_n3b[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
